gray_ptr_flag_ctrl: RTL and testbench

//  Per-domain pointer/flag controller for the async FIFO, one instance per clock side.

---
 rtl/gray_ptr_flag_ctrl.sv | 86 ++++++++
 tb/tb_gray_ptr_flag_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_flag_ctrl.sv
// Per-domain async-FIFO pointer/flag controller: binary + Gray pointer, full or empty flag, level, almost, err.
// Latency: an accepted inc updates ptr/addr/flag/level/almost on the same clock edge; all outputs registered.
// Backpressure: inc is ignored while flag is set (pointer held) and err pulses for one cycle instead.
module gray_ptr_flag_ctrl #(
  parameter int ADDR_W   = 4,
  parameter bit IS_WRITE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic [ADDR_W:0]   remote_ptr,
  input  logic [ADDR_W:0]   thresh,
  output logic [ADDR_W:0]   ptr,
  output logic [ADDR_W-1:0] addr,
  output logic              flag,
  output logic              almost,
  output logic [ADDR_W:0]   level,
  output logic              err
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] bin;
  logic [PTR_W-1:0] bin_nxt;
  logic [PTR_W-1:0] g_nxt;
  logic [PTR_W-1:0] remote_bin;
  logic [PTR_W-1:0] level_nxt;
  logic [PTR_W-1:0] full_pat;
  logic             inc_ok;
  logic             flag_nxt;
  logic             almost_nxt;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next pointer values, remote pointer decode, and next flag/level/almost.
  always_comb begin
    inc_ok     = inc & ~flag;
    bin_nxt    = bin + PTR_W'(inc_ok);
    g_nxt      = bin_nxt ^ (bin_nxt >> 1);
    remote_bin = gray2bin(remote_ptr);
    // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    full_pat   = {~remote_ptr[PTR_W-1:PTR_W-2], remote_ptr[PTR_W-3:0]};
    flag_nxt   = 1'b0;
    level_nxt  = '0;
    almost_nxt = 1'b0;
    if (IS_WRITE) begin
      flag_nxt   = (g_nxt == full_pat);
      level_nxt  = bin_nxt - remote_bin;
      almost_nxt = (level_nxt >= thresh);
    end else begin
      flag_nxt   = (g_nxt == remote_ptr);
      level_nxt  = remote_bin - bin_nxt;
      almost_nxt = (level_nxt <= thresh);
    end
  end

  // State and output registers; read side resets to empty/almost_empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin    <= '0;
      ptr    <= '0;
      addr   <= '0;
      level  <= '0;
      err    <= 1'b0;
      flag   <= ~IS_WRITE;
      almost <= ~IS_WRITE;
    end else begin
      bin    <= bin_nxt;
      ptr    <= g_nxt;
      addr   <= bin_nxt[ADDR_W-1:0];
      level  <= level_nxt;
      err    <= inc & flag;
      flag   <= flag_nxt;
      almost <= almost_nxt;
    end
  end

endmodule

// File: tb/tb_gray_ptr_flag_ctrl.sv
module tb_gray_ptr_flag_ctrl;

  logic       clk;
  logic       rst_n;

  logic       w_inc,  r_inc;
  logic [4:0] w_rptr, r_rptr;
  logic [4:0] w_thr,  r_thr;
  logic [4:0] w_ptr,  r_ptr;
  logic [3:0] w_addr, r_addr;
  logic       w_flag, r_flag;
  logic       w_alm,  r_alm;
  logic [4:0] w_lvl,  r_lvl;
  logic       w_err,  r_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Hand-computed Gray codes of 1..16.
  logic [4:0] gray_tab [16] = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
                                5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};

  gray_ptr_flag_ctrl #(.ADDR_W(4), .IS_WRITE(1'b1)) u_wr (
    .clk(clk), .rst_n(rst_n), .inc(w_inc), .remote_ptr(w_rptr), .thresh(w_thr),
    .ptr(w_ptr), .addr(w_addr), .flag(w_flag), .almost(w_alm), .level(w_lvl), .err(w_err)
  );

  gray_ptr_flag_ctrl #(.ADDR_W(4), .IS_WRITE(1'b0)) u_rd (
    .clk(clk), .rst_n(rst_n), .inc(r_inc), .remote_ptr(r_rptr), .thresh(r_thr),
    .ptr(r_ptr), .addr(r_addr), .flag(r_flag), .almost(r_alm), .level(r_lvl), .err(r_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] prev;
    rst_n  = 1'b0;
    w_inc  = 1'b0; r_inc  = 1'b0;
    w_rptr = '0;   r_rptr = '0;
    w_thr  = 5'd12; r_thr = 5'd2;
    step();
    step();

    // Reset values
    check("rst_w_ptr",   w_ptr,  0);
    check("rst_w_flag",  w_flag, 0);
    check("rst_w_alm",   w_alm,  0);
    check("rst_w_lvl",   w_lvl,  0);
    check("rst_w_err",   w_err,  0);
    check("rst_r_flag",  r_flag, 1);
    check("rst_r_alm",   r_alm,  1);
    check("rst_r_ptr",   r_ptr,  0);
    rst_n = 1'b1;

    // Fill write side to full, almost rising at level 12
    w_inc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("fill_ptr_%0d", i),  w_ptr,  gray_tab[i-1]);
      check($sformatf("fill_lvl_%0d", i),  w_lvl,  i);
      check($sformatf("fill_flag_%0d", i), w_flag, (i == 16));
      check($sformatf("fill_alm_%0d", i),  w_alm,  (i >= 12));
      check($sformatf("fill_err_%0d", i),  w_err,  0);
    end
    check("fill_addr", w_addr, 0);

    // Push while full: held pointer, err every cycle
    for (int i = 0; i < 3; i++) begin
      step();
      check("ovf_ptr",  w_ptr,  24);
      check("ovf_flag", w_flag, 1);
      check("ovf_err",  w_err,  1);
      check("ovf_lvl",  w_lvl,  16);
    end
    w_inc = 1'b0;
    step();
    check("ovf_err_clr", w_err, 0);

    // Remote pops drain level: 12 keeps almost, 11 drops it
    w_rptr = gray(4);
    step();
    check("drain_lvl12",  w_lvl,  12);
    check("drain_flag12", w_flag, 0);
    check("drain_alm12",  w_alm,  1);
    w_rptr = gray(5);
    step();
    check("drain_lvl11", w_lvl, 11);
    check("drain_alm11", w_alm, 0);

    // Wrap: local push and remote pop each cycle, 24 more accepted pushes
    w_inc = 1'b1;
    prev  = w_ptr;
    for (int j = 1; j <= 24; j++) begin
      w_rptr = gray(5 + j);
      step();
      check($sformatf("wrap_ptr_%0d", j),  w_ptr, gray(16 + j));
      check($sformatf("wrap_1bit_%0d", j), $countones(w_ptr ^ prev), 1);
      check($sformatf("wrap_lvl_%0d", j),  w_lvl,  11);
      check($sformatf("wrap_flag_%0d", j), w_flag, 0);
      prev = w_ptr;
    end
    check("wrap_ptr_final", w_ptr, 5'd12);
    w_inc = 1'b0;

    // Read side: 5 entries available
    r_rptr = gray(5);
    step();
    check("rd_flag_deassert", r_flag, 0);
    check("rd_lvl5",          r_lvl,  5);
    check("rd_alm5",          r_alm,  0);
    r_inc = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("pop_ptr_%0d", i),  r_ptr,  gray_tab[i-1]);
      check($sformatf("pop_lvl_%0d", i),  r_lvl,  5 - i);
      check($sformatf("pop_flag_%0d", i), r_flag, (i == 5));
      check($sformatf("pop_alm_%0d", i),  r_alm,  (i >= 3));
      check($sformatf("pop_err_%0d", i),  r_err,  0);
    end
    step();
    check("udf_err",  r_err,  1);
    check("udf_ptr",  r_ptr,  7);
    check("udf_lvl",  r_lvl,  0);
    check("udf_flag", r_flag, 1);
    r_inc = 1'b0;
    step();
    check("udf_err_clr", r_err, 0);

    // Async reset mid-burst
    r_rptr = gray(8);
    w_inc  = 1'b1;
    step();
    check("pre_rst_r_flag", r_flag, 0);
    check("pre_rst_r_lvl",  r_lvl,  3);
    check("pre_rst_w_ptr",  w_ptr,  gray(9));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_w_ptr",  w_ptr,  0);
    check("arst_w_addr", w_addr, 0);
    check("arst_w_lvl",  w_lvl,  0);
    check("arst_w_flag", w_flag, 0);
    check("arst_r_flag", r_flag, 1);
    check("arst_r_ptr",  r_ptr,  0);
    check("arst_r_lvl",  r_lvl,  0);
    w_inc = 1'b0;
    step();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
